enclosure_button: RTL and testbench

- Input-side companion to the enclosure LED driver: the LED driver writes the panel, this block reads it.
- Samples the two enclosure front-panel push buttons (raw, asynchronous, active-low).
- Per button: synchronises, debounces, and classifies each press as short or long.
- Publishes an 8-bit status register (same nibble-per-channel layout as the LED control register) and an interrupt flag for the management CPU/CPLD register file.

---
 rtl/enclosure_button.sv | 163 ++++++++++++++++
 tb/tb_enclosure_button.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/enclosure_button.sv
// Front-panel push-button reader: sync, debounce, short/long press
// classification, sticky status register and interrupt flag.
//
// Ports:
//   SYSCLK   system clock
//   RESET_N  asynchronous active-low reset
//   BTN0_N   raw button 0, active-low, asynchronous to SYSCLK
//   BTN1_N   raw button 1, active-low, asynchronous to SYSCLK
//   STS_CLR  write-1-to-clear strobe, aligned to BTN_REG bits
//   BTN_REG  status: per nibble {0, LONG, SHORT, pressed}
//   BTN_IRQ  registered OR of all sticky event bits
module enclosure_button #(
  parameter int CLK_FRQ     = 25000000,
  parameter int DB_CYCLES   = CLK_FRQ / 50,
  parameter int LONG_CYCLES = CLK_FRQ * 3
) (
  input  logic       SYSCLK,
  input  logic       RESET_N,
  input  logic       BTN0_N,
  input  logic       BTN1_N,
  input  logic [7:0] STS_CLR,
  output logic [7:0] BTN_REG,
  output logic       BTN_IRQ
);

  localparam int DW =
    (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HW =
    (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST =
    DW'(DB_CYCLES - 1);
  // hcnt reaches LONG_CYCLES-1 on the edge that
  // reports LONG, so the compare is one below that.
  localparam logic [HW-1:0] H_LAST =
    HW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG
  } st_t;

  logic [1:0] raw_n;
  logic [3:0] nib [2];
  logic [1:0] stk;
  logic       unused_clr;

  assign raw_n = {BTN1_N, BTN0_N};

  assign unused_clr = ^{STS_CLR[7], STS_CLR[4],
                        STS_CLR[3], STS_CLR[0]};

  for (genvar n = 0; n < 2; n++) begin : g_ch
    logic          s1_n;
    logic          s2_n;
    logic          s;
    logic          db;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    st_t           st;
    logic          sh_q;
    logic          lg_q;
    logic          ev_sh;
    logic          ev_lg;

    // Flops keep raw polarity so reset means
    // released; s is the pressed view.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        s1_n <= 1'b1;
        s2_n <= 1'b1;
      end else begin
        s1_n <= raw_n[n];
        s2_n <= s1_n;
      end
    end

    assign s = ~s2_n;

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        db   <= 1'b0;
        dcnt <= '0;
      end else if (s == db) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        db   <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end

    always_comb begin
      ev_sh = 1'b0;
      ev_lg = 1'b0;
      if (st == ST_PRESSED) begin
        ev_sh = ~db;
        ev_lg = db & (hcnt == H_LAST);
      end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        st   <= ST_IDLE;
        hcnt <= '0;
      end else begin
        unique case (st)
          ST_IDLE: begin
            if (db) begin
              st   <= ST_PRESSED;
              hcnt <= '0;
            end
          end
          ST_PRESSED: begin
            if (!db) begin
              st <= ST_IDLE;
            end else begin
              hcnt <= hcnt + HW'(1);
              if (hcnt == H_LAST) begin
                st <= ST_LONG;
              end
            end
          end
          ST_LONG: begin
            if (!db) begin
              st <= ST_IDLE;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end

    // Set beats clear so an event is never lost.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        sh_q <= 1'b0;
        lg_q <= 1'b0;
      end else begin
        sh_q <= ev_sh |
                (sh_q & ~STS_CLR[4*n+1]);
        lg_q <= ev_lg |
                (lg_q & ~STS_CLR[4*n+2]);
      end
    end

    assign nib[n] = {1'b0, lg_q, sh_q, db};
    assign stk[n] = sh_q | lg_q;
  end

  assign BTN_REG = {nib[1], nib[0]};

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      BTN_IRQ <= 1'b0;
    end else begin
      BTN_IRQ <= |stk;
    end
  end

endmodule

// File: tb/tb_enclosure_button.sv
// Scoreboard bench for enclosure_button: a driver feeds a
// history-window reference model; a monitor checks each cycle.
module tb_enclosure_button;

  localparam int DB = 4;
  localparam int LG = 16;

  logic       SYSCLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BTN0_N = 1'b1;
  logic       BTN1_N = 1'b1;
  logic [7:0] STS_CLR = 8'h00;
  logic [7:0] BTN_REG;
  logic       BTN_IRQ;

  enclosure_button #(
    .CLK_FRQ    (200),
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LG)
  ) dut (
    .SYSCLK (SYSCLK),
    .RESET_N(RESET_N),
    .BTN0_N (BTN0_N),
    .BTN1_N (BTN1_N),
    .STS_CLR(STS_CLR),
    .BTN_REG(BTN_REG),
    .BTN_IRQ(BTN_IRQ)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed {
    logic [7:0] r;
    logic       i;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: pressed levels pass a two-sample
  // delay, then db flips once the last DB samples all
  // disagree with it. A press is classified by elapsed
  // edges since db rose.
  bit [1:0]    dl [2];
  bit [DB-1:0] win [2];
  bit          db [2];
  bit          open [2];
  int          start [2];
  bit          shs [2];
  bit          lgs [2];
  bit          irq_m;
  int          edge_n;
  int          collide_hits = 0;

  function automatic void mdl_reset();
    for (int n = 0; n < 2; n++) begin
      dl[n]   = '0;
      win[n]  = '0;
      db[n]   = 1'b0;
      open[n] = 1'b0;
      shs[n]  = 1'b0;
      lgs[n]  = 1'b0;
    end
    irq_m = 1'b0;
  endfunction

  function automatic bit short_next(int n);
    return open[n] && !db[n];
  endfunction

  function automatic void mdl_step(
    bit rst_n, bit [1:0] p, bit [7:0] clr);
    bit irq_new;
    bit seen;
    bit ev_s;
    bit ev_l;
    exp_t e;
    if (!rst_n) begin
      mdl_reset();
    end else begin
      edge_n++;
      irq_new = shs[0] | shs[1] | lgs[0] | lgs[1];
      for (int n = 0; n < 2; n++) begin
        ev_s = 1'b0;
        ev_l = 1'b0;
        if (open[n] && !db[n]) begin
          ev_s = 1'b1;
          open[n] = 1'b0;
        end else if (open[n] &&
                     edge_n == start[n] + LG) begin
          ev_l = 1'b1;
          open[n] = 1'b0;
        end
        seen = dl[n][1];
        dl[n] = {dl[n][0], p[n]};
        win[n] = {win[n][DB-2:0], seen};
        if (!db[n] && win[n] == '1) begin
          db[n] = 1'b1;
          open[n] = 1'b1;
          start[n] = edge_n;
        end else if (db[n] && win[n] == '0) begin
          db[n] = 1'b0;
        end
        shs[n] = ev_s | (shs[n] & ~clr[4*n+1]);
        lgs[n] = ev_l | (lgs[n] & ~clr[4*n+2]);
      end
      irq_m = irq_new;
    end
    e.r = {1'b0, lgs[1], shs[1], db[1],
           1'b0, lgs[0], shs[0], db[0]};
    e.i = irq_m;
    q.push_back(e);
  endfunction

  task automatic cyc(input bit rst_n, input bit b0,
                     input bit b1, input bit [7:0] clr);
    @(negedge SYSCLK);
    RESET_N = rst_n;
    BTN0_N  = ~b0;
    BTN1_N  = ~b1;
    STS_CLR = clr;
    mdl_step(rst_n, {b1, b0}, clr);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1, 0, 0, 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge SYSCLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (BTN_REG !== e.r) begin
          bad++;
          $display("FAIL btn_reg t=%0t got=%h exp=%h",
                   $time, BTN_REG, e.r);
        end
        total++;
        if (BTN_IRQ !== e.i) begin
          bad++;
          $display("FAIL btn_irq t=%0t got=%b exp=%b",
                   $time, BTN_IRQ, e.i);
        end
      end
    end
  end

  initial begin : driver
    int  rem [2];
    bit  lvl [2];
    bit  [7:0] clr;
    edge_n = 0;
    mdl_reset();

    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 8'h00);
    idle(8);

    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 8'h00);
    idle(10);

    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 8'h00);
    idle(12);
    cyc(1, 0, 0, 8'h02);
    idle(4);

    for (int i = 0; i < 30; i++) cyc(1, 0, 1, 8'h00);
    idle(12);
    cyc(1, 0, 0, 8'h40);
    idle(4);

    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      if (short_next(0)) begin
        collide_hits++;
        cyc(1, 0, 0, 8'h02);
      end else begin
        cyc(1, 0, 0, 8'h00);
      end
    end
    idle(3);
    cyc(1, 0, 0, 8'hff);
    idle(4);

    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00);
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, 8'h00);
    idle(12);
    cyc(1, 0, 0, 8'hff);
    idle(4);

    for (int j = 0; j < 2; j++) begin
      rem[j] = 0;
      lvl[j] = 1'b0;
    end
    for (int i = 0; i < 2000; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (rem[j] == 0) begin
          lvl[j] = 1'($urandom_range(0, 1));
          rem[j] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 3)) :
                   int'($urandom_range(4, 30));
        end
        rem[j]--;
      end
      clr = ($urandom_range(0, 7) == 0) ?
            8'($urandom) : 8'h00;
      if ($urandom_range(0, 399) == 0) begin
        cyc(0, lvl[0], lvl[1], clr);
      end else begin
        cyc(1, lvl[0], lvl[1], clr);
      end
    end
    idle(40);

    @(posedge SYSCLK);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    total++;
    if (collide_hits != 1) begin
      bad++;
      $display("FAIL collide hits=%0d exp=1",
               collide_hits);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
